uart_frame_tx: RTL and testbench

Parametrised multi-byte UART transmitter. It latches an `NBYTES`-wide word on a start strobe and serialises it byte by byte onto `uart_tx`, using 8N1/8O1/8E1 framing and one or two stop bits. An optional idle gap can be inserted between bytes. It is the successor to the fixed 5-byte, fixed-115200 sender: it adds a start/busy/done handshake, selectable byte order, parity, stop-bit count and baud rate, and sits between the sample/packet logic and the board UART pin.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_frame_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_frame_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the multi-byte UART transmitter.
// FSM states, parity codes and the baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_GAP
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded clock cycles per bit period.
  function automatic int baud_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick pulses every DIV cycles, restart on clr.
// Ports: sys_clk, sys_rst (sync, high), clr, tick.
module uart_baud_tick #(
  parameter int DIV = 434
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART sender with start/busy/done handshake.
// Ports: sys_clk, sys_rst, start, data in; busy, done, uart_tx out.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115200,
  parameter int NBYTES         = 5,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int MSB_BYTE_FIRST = 1,
  parameter int GAP_BITS       = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] data,
  output logic                busy,
  output logic                done,
  output logic                uart_tx
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (NBYTES < 1) begin : g_chk_nb
    $error("NBYTES must be >= 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_chk_par
    $error("PARITY must be 0..2");
  end
  if (BAUD_DIV < 2) begin : g_chk_div
    $error("BAUD_DIV must be >= 2");
  end

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [15:0]    bc_q, bc_d;
  logic [W-1:0]   word_q, word_d;
  logic           tx_q, tx_d;
  logic           clr, tick, done_c, last;
  logic [IW-1:0]  sel_d;
  logic [7:0]     cur_d;

  uart_baud_tick #(
    .DIV(BAUD_DIV)
  ) u_tick (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .clr    (clr),
    .tick   (tick)
  );

  assign last = (idx_q == IW'(NBYTES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bc_d    = bc_q;
    word_d  = word_q;
    clr     = 1'b0;
    done_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_START;
          idx_d   = '0;
          bc_d    = '0;
          word_d  = data;
          clr     = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bc_d    = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bc_q == 16'd7) begin
            state_d = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
            bc_d    = '0;
          end else begin
            bc_d = bc_q + 16'd1;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          state_d = S_STOP;
          bc_d    = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bc_q == 16'(STOP_BITS - 1)) begin
            bc_d = '0;
            if (last) begin
              state_d = S_IDLE;
              done_c  = 1'b1;
            end else if (GAP_BITS > 0) begin
              state_d = S_GAP;
            end else begin
              state_d = S_START;
              idx_d   = idx_q + 1'b1;
            end
          end else begin
            bc_d = bc_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (bc_q == 16'(GAP_BITS - 1)) begin
            state_d = S_START;
            idx_d   = idx_q + 1'b1;
            bc_d    = '0;
          end else begin
            bc_d = bc_q + 16'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered, so it is derived from the next state.
  always_comb begin
    sel_d = (MSB_BYTE_FIRST != 0) ? (IW'(NBYTES - 1) - idx_d) : idx_d;
    cur_d = word_d[8*sel_d +: 8];
    tx_d  = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_d[bc_d[2:0]];
      S_PAR:   tx_d = (PARITY == PAR_ODD) ? ~^cur_d : ^cur_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bc_q    <= '0;
      word_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bc_q    <= bc_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
    end
  end

  assign busy    = (state_q != S_IDLE) && !done_c;
  assign done    = done_c;
  assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx across four parameter sets.
// Line bits sampled mid-period against a frame model.
module tb_uart_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst;
  logic [3:0]  start_v;
  logic [39:0] data_v [4];
  logic        tx0, tx1, tx2, tx3;
  logic        bz0, bz1, bz2, bz3;
  logic        dn0, dn1, dn2, dn3;
  logic [3:0]  tx_v, busy_v, done_v;

  assign tx_v   = {tx3, tx2, tx1, tx0};
  assign busy_v = {bz3, bz2, bz1, bz0};
  assign done_v = {dn3, dn2, dn1, dn0};

  uart_frame_tx u0 (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[0]),
    .data(data_v[0]), .busy(bz0), .done(dn0), .uart_tx(tx0)
  );

  uart_frame_tx #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .MSB_BYTE_FIRST(0)
  ) u1 (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[1]),
    .data(data_v[1]), .busy(bz1), .done(dn1), .uart_tx(tx1)
  );

  uart_frame_tx #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .NBYTES(1),
    .PARITY(2), .STOP_BITS(2)
  ) u2 (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[2]),
    .data(data_v[2][7:0]), .busy(bz2), .done(dn2), .uart_tx(tx2)
  );

  uart_frame_tx #(
    .CLK_FREQ(1_000_000), .BAUD(100_000), .NBYTES(2),
    .GAP_BITS(3)
  ) u3 (
    .sys_clk(clk), .sys_rst(sys_rst), .start(start_v[3]),
    .data(data_v[3][15:0]), .busy(bz3), .done(dn3), .uart_tx(tx3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected line, bit k = level during the k-th bit period.
  function automatic logic [63:0] line_bits(
    input logic [39:0] d, input int nb, input int msb,
    input int par, input int stop, input int gap);
    logic [63:0] r;
    logic [7:0]  b;
    int k, sel;
    r = '1;
    k = 0;
    for (int i = 0; i < nb; i++) begin
      sel = (msb != 0) ? nb - 1 - i : i;
      b = d[8*sel +: 8];
      r[k] = 1'b0; k++;
      for (int j = 0; j < 8; j++) begin r[k] = b[j]; k++; end
      if (par == 1) begin r[k] = ~^b; k++; end
      if (par == 2) begin r[k] = ^b;  k++; end
      for (int j = 0; j < stop; j++) begin r[k] = 1'b1; k++; end
      if (i < nb - 1)
        for (int j = 0; j < gap; j++) begin r[k] = 1'b1; k++; end
    end
    return r;
  endfunction

  typedef struct {
    int          id;
    logic [39:0] d;
    int          t;
    int          div;
    int          nb, msb, par, stop, gap;
    bit          repulse;
    bit          hold;
  } vec_t;

  vec_t vecs [4];

  task automatic run_frame(input vec_t v);
    logic [63:0] bits;
    int dn_cnt, dn_at, last_c, k;
    bits   = line_bits(v.d, v.nb, v.msb, v.par, v.stop, v.gap);
    dn_cnt = 0;
    dn_at  = -1;
    last_c = v.hold ? v.t + 2 : v.t + 1;
    @(negedge clk);
    start_v[v.id] = 1'b1;
    data_v[v.id]  = v.d;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk($sformatf("u%0d busy@1", v.id), 64'(busy_v[v.id]), 64'd1);
        chk($sformatf("u%0d tx@1", v.id), 64'(tx_v[v.id]), 64'd0);
        start_v[v.id] = 1'b0;
      end
      if (c <= v.t && ((c - 1) % v.div) == v.div / 2) begin
        k = (c - 1) / v.div;
        chk($sformatf("u%0d bit%0d", v.id, k),
            64'(tx_v[v.id]), 64'(bits[k]));
      end
      if (c <= v.t + 1 && done_v[v.id]) begin
        dn_cnt++;
        dn_at = c;
      end
      if (c == v.t - 1)
        chk($sformatf("u%0d busy@T-1", v.id), 64'(busy_v[v.id]), 64'd1);
      if (c == v.t) begin
        chk($sformatf("u%0d busy@T", v.id), 64'(busy_v[v.id]), 64'd0);
        chk($sformatf("u%0d tx@T", v.id), 64'(tx_v[v.id]), 64'd1);
      end
      if (v.hold && c == v.t + 1) begin
        chk("hold tx@T+1", 64'(tx_v[v.id]), 64'd1);
        chk("hold busy@T+1", 64'(busy_v[v.id]), 64'd0);
      end
      if (v.hold && c == v.t + 2) begin
        chk("hold tx@T+2", 64'(tx_v[v.id]), 64'd0);
        chk("hold busy@T+2", 64'(busy_v[v.id]), 64'd1);
        start_v[v.id] = 1'b0;
      end
      if (v.repulse && c == 5000) begin
        start_v[v.id] = 1'b1;
        data_v[v.id]  = 40'hFF_EE_DD_CC_BB;
      end
      if (v.repulse && c == 5001) begin
        start_v[v.id] = 1'b0;
        data_v[v.id]  = v.d;
      end
      if (v.hold && c == v.t - 1) begin
        start_v[v.id] = 1'b1;
        data_v[v.id]  = v.d;
      end
    end
    chk($sformatf("u%0d done count", v.id), 64'(dn_cnt), 64'd1);
    chk($sformatf("u%0d done cycle", v.id), 64'(dn_at), 64'(v.t));
  endtask

  initial begin
    int dn;
    sys_rst = 1'b1;
    start_v = '0;
    for (int i = 0; i < 4; i++) data_v[i] = '0;

    vecs[0] = '{1, 40'h10_08_04_02_01, 500, 10, 5, 0, 0, 1, 0, 1'b0, 1'b0};
    vecs[1] = '{2, 40'h07, 120, 10, 1, 1, 2, 2, 0, 1'b0, 1'b0};
    vecs[2] = '{3, 40'hA53C, 230, 10, 2, 1, 0, 1, 3, 1'b0, 1'b0};
    vecs[3] = '{0, 40'h10_08_04_02_01, 21700, 434, 5, 1, 0, 1, 0,
                1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst tx", 64'(tx_v), 64'hF);
    chk("rst busy", 64'(busy_v), 64'h0);
    chk("rst done", 64'(done_v), 64'h0);

    // Reset and start together: reset wins.
    start_v[1] = 1'b1;
    data_v[1]  = 40'h55;
    @(negedge clk);
    chk("rst+start tx", 64'(tx_v[1]), 64'd1);
    chk("rst+start busy", 64'(busy_v[1]), 64'd0);
    start_v[1] = 1'b0;
    sys_rst    = 1'b0;
    @(negedge clk);
    chk("rst+start busy2", 64'(busy_v[1]), 64'd0);

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Second u0 frame accepted at T+1; reset it during byte 3.
    dn = 0;
    for (int j = 2; j <= 8881; j++) begin
      @(negedge clk);
      if (done_v[0]) dn++;
    end
    chk("pre-rst busy", 64'(busy_v[0]), 64'd1);
    sys_rst = 1'b1;
    @(negedge clk);
    chk("midrst tx", 64'(tx_v[0]), 64'd1);
    chk("midrst busy", 64'(busy_v[0]), 64'd0);
    chk("midrst done", 64'(done_v[0]), 64'd0);
    sys_rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done_v[0]) dn++;
    end
    chk("midrst no done", 64'(dn), 64'd0);
    chk("midrst idle tx", 64'(tx_v[0]), 64'd1);

    vecs[3].repulse = 1'b0;
    vecs[3].hold    = 1'b0;
    run_frame(vecs[3]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
